// File: rtl/branch_fb_pkg.sv
// Shared types and helpers for the branch feedback queue.
package branch_fb_pkg;

    localparam int unsigned ADDR_WIDTH = 32;

    // One in-flight branch as recorded at decode.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  prediction;
        logic [ADDR_WIDTH-1:0] target;
    } bfq_entry_t;

    // Wrong direction, or right "taken" direction to the wrong place.
    function automatic logic is_mispredict(input bfq_entry_t            entry,
                                           input logic                  taken,
                                           input logic [ADDR_WIDTH-1:0] target);
        return (entry.prediction != taken) || (taken && (entry.target != target));
    endfunction

endpackage

// File: rtl/branch_feedback_queue_if.sv
// Decode request, execute result and predictor feedback bundle.
interface branch_feedback_queue_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  dec_valid;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic                  dec_prediction;
    logic [ADDR_WIDTH-1:0] dec_target;
    logic                  ex_valid;
    logic [ADDR_WIDTH-1:0] ex_pc;
    logic                  ex_taken;
    logic [ADDR_WIDTH-1:0] ex_target;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  fb_valid;
    logic [ADDR_WIDTH-1:0] fb_pc;
    logic                  fb_prediction;
    logic                  fb_outcome;
    logic                  fb_mispredict;
    logic                  error;

    modport master (
        output dec_valid, dec_pc, dec_prediction, dec_target,
        output ex_valid, ex_pc, ex_taken, ex_target,
        input  full, empty, count,
        input  fb_valid, fb_pc, fb_prediction, fb_outcome, fb_mispredict, error
    );

    modport slave (
        input  dec_valid, dec_pc, dec_prediction, dec_target,
        input  ex_valid, ex_pc, ex_taken, ex_target,
        output full, empty, count,
        output fb_valid, fb_pc, fb_prediction, fb_outcome, fb_mispredict, error
    );

endinterface

// File: rtl/bfq_ring.sv
// Circular storage of in-flight branches with head/tail pointers and occupancy.
module bfq_ring import branch_fb_pkg::*; #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  bfq_entry_t       wr_entry_i,
    output bfq_entry_t       rd_entry_o,
    output logic [CNT_W-1:0] count_o
);

    bfq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= wr_entry_i;
        end
    end

    // Pointer and occupancy next-state; clear wins over push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = PTR_W'(tail_q + PTR_W'(1));
            if (pop_i)  head_d = PTR_W'(head_q + PTR_W'(1));
            count_d = CNT_W'(count_q + CNT_W'(push_i) - CNT_W'(pop_i));
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rd_entry_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/branch_feedback_queue.sv
// Holds predicted branches until execute resolves them, then emits predictor training records.
module branch_feedback_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    branch_feedback_queue_if.slave bus
);
    import branch_fb_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    bfq_entry_t       head_entry;
    bfq_entry_t       wr_entry;
    logic [CNT_W-1:0] count;
    logic             empty_c, full_c;
    logic             pop_c, push_c, clear_c, match_c, mispredict_c;

    logic                  fb_valid_q,      fb_valid_d;
    logic [ADDR_WIDTH-1:0] fb_pc_q,         fb_pc_d;
    logic                  fb_prediction_q, fb_prediction_d;
    logic                  fb_outcome_q,    fb_outcome_d;
    logic                  fb_mispredict_q, fb_mispredict_d;
    logic                  error_q,         error_d;

    assign wr_entry = '{pc: bus.dec_pc, prediction: bus.dec_prediction, target: bus.dec_target};

    bfq_ring #(.DEPTH(DEPTH)) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_c),
        .pop_i      (pop_c),
        .clear_i    (clear_c),
        .wr_entry_i (wr_entry),
        .rd_entry_o (head_entry),
        .count_o    (count)
    );

    // Push/pop qualification, resolve compare and next feedback record.
    always_comb begin
        empty_c         = (count == '0);
        full_c          = (count == CNT_W'(DEPTH));
        pop_c           = bus.ex_valid && !empty_c;
        match_c         = (head_entry.pc == bus.ex_pc);
        mispredict_c    = is_mispredict(head_entry, bus.ex_taken, bus.ex_target);
        // A resolved mispredict squashes everything younger, including this cycle's push.
        clear_c         = pop_c && match_c && mispredict_c;
        push_c          = bus.dec_valid && (!full_c || pop_c) && !clear_c;

        fb_valid_d      = pop_c && match_c;
        fb_pc_d         = fb_pc_q;
        fb_prediction_d = fb_prediction_q;
        fb_outcome_d    = fb_outcome_q;
        fb_mispredict_d = fb_mispredict_q;
        if (pop_c && match_c) begin
            fb_pc_d         = head_entry.pc;
            fb_prediction_d = head_entry.prediction;
            fb_outcome_d    = bus.ex_taken;
            fb_mispredict_d = mispredict_c;
        end

        error_d = (bus.ex_valid && empty_c)
                || (pop_c && !match_c)
                || (bus.dec_valid && full_c && !pop_c);
    end

    // Feedback and error output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_valid_q      <= 1'b0;
            fb_pc_q         <= '0;
            fb_prediction_q <= 1'b0;
            fb_outcome_q    <= 1'b0;
            fb_mispredict_q <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            fb_valid_q      <= fb_valid_d;
            fb_pc_q         <= fb_pc_d;
            fb_prediction_q <= fb_prediction_d;
            fb_outcome_q    <= fb_outcome_d;
            fb_mispredict_q <= fb_mispredict_d;
            error_q         <= error_d;
        end
    end

    assign bus.full          = full_c;
    assign bus.empty         = empty_c;
    assign bus.count         = count;
    assign bus.fb_valid      = fb_valid_q;
    assign bus.fb_pc         = fb_pc_q;
    assign bus.fb_prediction = fb_prediction_q;
    assign bus.fb_outcome    = fb_outcome_q;
    assign bus.fb_mispredict = fb_mispredict_q;
    assign bus.error         = error_q;

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Self-checking bench for branch_feedback_queue: directed table, corner sequences, random vs. queue model.
module tb_branch_feedback_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    branch_feedback_queue_if #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    branch_feedback_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-ordered queue of outstanding branches.
    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } m_ent_t;

    m_ent_t      mq[$];
    logic [31:0] m_pc;
    logic        m_pred, m_out, m_mis;

    typedef struct {
        logic        dv;
        logic [31:0] dpc;
        logic        dpred;
        logic        xv;
        logic [31:0] xpc;
        logic        xt;
        logic [31:0] xtgt;
        int          exp_count;
        logic        exp_fbv;
        logic        exp_err;
        logic        exp_mis;
        logic        exp_out;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic dv, input logic [31:0] dpc, input logic dpred,
                                input logic xv, input logic [31:0] xpc, input logic xt,
                                input logic [31:0] xtgt, input int cnt, input logic fbv,
                                input logic err, input logic mis, input logic out,
                                input logic [31:0] pc);
        vec_t v;
        v.dv = dv; v.dpc = dpc; v.dpred = dpred;
        v.xv = xv; v.xpc = xpc; v.xt = xt; v.xtgt = xtgt;
        v.exp_count = cnt; v.exp_fbv = fbv; v.exp_err = err;
        v.exp_mis = mis; v.exp_out = out; v.exp_pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = '0; m_pred = 1'b0; m_out = 1'b0; m_mis = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    64'(bus.count), 64'(0));
        check({tag, "_empty"},    64'(bus.empty), 64'(1));
        check({tag, "_full"},     64'(bus.full), 64'(0));
        check({tag, "_fb_valid"}, 64'(bus.fb_valid), 64'(0));
        check({tag, "_fb_pc"},    64'(bus.fb_pc), 64'(0));
        check({tag, "_fb_pred"},  64'(bus.fb_prediction), 64'(0));
        check({tag, "_fb_out"},   64'(bus.fb_outcome), 64'(0));
        check({tag, "_fb_mis"},   64'(bus.fb_mispredict), 64'(0));
        check({tag, "_error"},    64'(bus.error), 64'(0));
    endtask

    // One clock: update the model from the rules, drive, clock, compare every output.
    task automatic step(input logic dv, input logic [31:0] dpc, input logic dpred,
                        input logic [31:0] dtgt, input logic xv, input logic [31:0] xpc,
                        input logic xt, input logic [31:0] xtgt);
        m_ent_t h;
        m_ent_t n;
        logic   e_err, e_fbv, flush, popped;
        int     sz;
        e_err = 1'b0; e_fbv = 1'b0; flush = 1'b0; popped = 1'b0;
        sz = mq.size();
        if (xv) begin
            if (sz == 0) begin
                e_err = 1'b1;
            end else begin
                h = mq[0];
                popped = 1'b1;
                if (h.pc == xpc) begin
                    e_fbv  = 1'b1;
                    m_pc   = h.pc;
                    m_pred = h.pred;
                    m_out  = xt;
                    m_mis  = (h.pred != xt) || (xt && (h.tgt != xtgt));
                    flush  = m_mis;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
        if (popped) void'(mq.pop_front());
        if (flush) begin
            mq.delete();
        end else if (dv) begin
            if (sz < int'(DEPTH) || popped) begin
                n.pc = dpc; n.pred = dpred; n.tgt = dtgt;
                mq.push_back(n);
            end else begin
                e_err = 1'b1;
            end
        end

        bus.dec_valid = dv;  bus.dec_pc = dpc; bus.dec_prediction = dpred; bus.dec_target = dtgt;
        bus.ex_valid  = xv;  bus.ex_pc  = xpc; bus.ex_taken = xt;          bus.ex_target  = xtgt;
        @(posedge clk);
        #1;
        check("count",    64'(bus.count), 64'(mq.size()));
        check("full",     64'(bus.full), 64'(mq.size() == int'(DEPTH)));
        check("empty",    64'(bus.empty), 64'(mq.size() == 0));
        check("fb_valid", 64'(bus.fb_valid), 64'(e_fbv));
        check("error",    64'(bus.error), 64'(e_err));
        check("fb_pc",    64'(bus.fb_pc), 64'(m_pc));
        check("fb_pred",  64'(bus.fb_prediction), 64'(m_pred));
        check("fb_out",   64'(bus.fb_outcome), 64'(m_out));
        check("fb_mis",   64'(bus.fb_mispredict), 64'(m_mis));
    endtask

    task automatic idle_inputs();
        bus.dec_valid = 1'b0; bus.dec_pc = '0; bus.dec_prediction = 1'b0; bus.dec_target = '0;
        bus.ex_valid  = 1'b0; bus.ex_pc  = '0; bus.ex_taken = 1'b0;       bus.ex_target  = '0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc_w, tgt_w, xpc_w, xtgt_w;
        logic        dv_r, dp_r, xv_r, xt_r;

        tests = 0;
        failed = 0;
        model_reset();
        idle_inputs();
        rst_n = 1'b0;

        // Directed table: fill/overflow, drain, empty pop, mispredict flush, pc mismatch, no bypass.
        vt[0]  = mk(1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 0, 32'h0);
        vt[1]  = mk(1, 32'h104, 0, 0, 32'h0,   0, 32'h0,   2, 0, 0, 0, 0, 32'h0);
        vt[2]  = mk(1, 32'h108, 0, 0, 32'h0,   0, 32'h0,   3, 0, 0, 0, 0, 32'h0);
        vt[3]  = mk(1, 32'h10C, 0, 0, 32'h0,   0, 32'h0,   4, 0, 0, 0, 0, 32'h0);
        vt[4]  = mk(1, 32'h110, 0, 0, 32'h0,   0, 32'h0,   4, 0, 1, 0, 0, 32'h0);
        vt[5]  = mk(1, 32'h110, 0, 1, 32'h100, 0, 32'h0,   4, 1, 0, 0, 0, 32'h100);
        vt[6]  = mk(0, 32'h0,   0, 1, 32'h104, 0, 32'h0,   3, 1, 0, 0, 0, 32'h104);
        vt[7]  = mk(0, 32'h0,   0, 1, 32'h108, 0, 32'h0,   2, 1, 0, 0, 0, 32'h108);
        vt[8]  = mk(0, 32'h0,   0, 1, 32'h10C, 0, 32'h0,   1, 1, 0, 0, 0, 32'h10C);
        vt[9]  = mk(0, 32'h0,   0, 1, 32'h110, 0, 32'h0,   0, 1, 0, 0, 0, 32'h110);
        vt[10] = mk(0, 32'h0,   0, 1, 32'h500, 0, 32'h0,   0, 0, 1, 0, 0, 32'h0);
        vt[11] = mk(1, 32'h200, 1, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 0, 32'h0);
        vt[12] = mk(1, 32'h204, 0, 0, 32'h0,   0, 32'h0,   2, 0, 0, 0, 0, 32'h0);
        vt[13] = mk(1, 32'h208, 0, 0, 32'h0,   0, 32'h0,   3, 0, 0, 0, 0, 32'h0);
        vt[14] = mk(1, 32'h20C, 0, 1, 32'h200, 1, 32'h340, 0, 1, 0, 1, 1, 32'h200);
        vt[15] = mk(1, 32'h400, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 0, 32'h0);
        vt[16] = mk(1, 32'h408, 0, 0, 32'h0,   0, 32'h0,   2, 0, 0, 0, 0, 32'h0);
        vt[17] = mk(0, 32'h0,   0, 1, 32'h404, 0, 32'h0,   1, 0, 1, 0, 0, 32'h0);
        vt[18] = mk(0, 32'h0,   0, 1, 32'h408, 0, 32'h0,   0, 1, 0, 0, 0, 32'h408);
        vt[19] = mk(1, 32'h500, 0, 1, 32'h500, 0, 32'h0,   1, 0, 1, 0, 0, 32'h0);
        vt[20] = mk(0, 32'h0,   0, 1, 32'h500, 0, 32'h0,   0, 1, 0, 0, 0, 32'h500);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Predicted target is pc + 0x100 (so 0x200 predicts 0x300).
        for (int i = 0; i < 21; i++) begin
            step(vt[i].dv, vt[i].dpc, vt[i].dpred, vt[i].dpc + 32'h100,
                 vt[i].xv, vt[i].xpc, vt[i].xt, vt[i].xtgt);
            check($sformatf("tbl%0d_count", i), 64'(bus.count), 64'(vt[i].exp_count));
            check($sformatf("tbl%0d_fbv", i),   64'(bus.fb_valid), 64'(vt[i].exp_fbv));
            check($sformatf("tbl%0d_err", i),   64'(bus.error), 64'(vt[i].exp_err));
            if (vt[i].exp_fbv) begin
                check($sformatf("tbl%0d_pc", i),  64'(bus.fb_pc), 64'(vt[i].exp_pc));
                check($sformatf("tbl%0d_mis", i), 64'(bus.fb_mispredict), 64'(vt[i].exp_mis));
                check($sformatf("tbl%0d_out", i), 64'(bus.fb_outcome), 64'(vt[i].exp_out));
            end
        end

        // Pointer wrap: staggered push/pop pairs with alternating predictions.
        for (int i = 0; i <= 10; i++) begin
            pc_w   = 32'h600 + 32'(4 * i);
            tgt_w  = 32'h700 + 32'(4 * i);
            xpc_w  = 32'h600 + 32'(4 * (i - 1));
            xtgt_w = 32'h700 + 32'(4 * (i - 1));
            step(i < 10, pc_w, 1'(i % 2), tgt_w, i > 0, xpc_w, 1'((i + 1) % 2), xtgt_w);
            if (i > 0) begin
                check($sformatf("wrap%0d_fbv", i),  64'(bus.fb_valid), 64'(1));
                check($sformatf("wrap%0d_pc", i),   64'(bus.fb_pc), 64'(xpc_w));
                check($sformatf("wrap%0d_pred", i), 64'(bus.fb_prediction), 64'((i + 1) % 2));
                check($sformatf("wrap%0d_mis", i),  64'(bus.fb_mispredict), 64'(0));
            end
        end

        // Mid-stream asynchronous reset with a feedback pulse and a pending entry live.
        step(1, 32'h800, 1, 32'h900, 0, 32'h0,   0, 32'h0);
        step(1, 32'h804, 0, 32'h904, 1, 32'h800, 1, 32'h900);
        check("pre_rst_fbv", 64'(bus.fb_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        rst_n = 1'b1;

        // Random traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            dv_r   = ($urandom_range(0, 99) < 60);
            pc_w   = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            dp_r   = 1'($urandom_range(0, 1));
            tgt_w  = 32'h2000 + (32'($urandom_range(0, 3)) << 4);
            xv_r   = ($urandom_range(0, 99) < 55);
            xpc_w  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            xtgt_w = 32'h2000 + (32'($urandom_range(0, 3)) << 4);
            xt_r   = 1'($urandom_range(0, 1));
            if (mq.size() > 0) begin
                if ($urandom_range(0, 99) < 85) xpc_w  = mq[0].pc;
                if ($urandom_range(0, 99) < 75) xt_r   = mq[0].pred;
                if ($urandom_range(0, 99) < 70) xtgt_w = mq[0].tgt;
            end
            step(dv_r, pc_w, dp_r, tgt_w, xv_r, xpc_w, xt_r, xtgt_w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
